// File: rtl/bcd_pkg.sv
// Shared BCD digit constants and helpers for the up/down BCD counter.
package bcd_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   // Non-decimal nibbles (10..15) collapse to zero
   function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] d);
      return (d > BCD_MAX) ? BCD_MIN : d;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade digit built from four JK cells; J/K derived from load, step and direction.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             step,
   input  logic             up_dn,
   input  logic             load,
   input  logic [BCD_W-1:0] d,
   output logic [BCD_W-1:0] q,
   output logic             is_max,
   output logic             is_min
);

   logic [BCD_W-1:0] q_w;
   logic [BCD_W-1:0] nxt;
   logic [BCD_W-1:0] j;
   logic [BCD_W-1:0] k;

   // J sets bits that must rise, K clears bits that must fall
   always_comb begin
      nxt = q_w;
      j   = '0;
      k   = '0;
      if (load) begin
         j = bcd_sanitize(d);
         k = ~bcd_sanitize(d);
      end else if (step) begin
         if (up_dn) nxt = (q_w == BCD_MAX) ? BCD_MIN : BCD_W'(q_w + 4'd1);
         else       nxt = (q_w == BCD_MIN) ? BCD_MAX : BCD_W'(q_w - 4'd1);
         j = nxt & ~q_w;
         k = ~nxt & q_w;
      end
   end

   for (genvar b = 0; b < BCD_W; b++) begin : g_bit
      edge_trigger_JKFF u_ff (
         .clk     (clk),
         .reset_n (reset_n),
         .j       (j[b]),
         .k       (k[b]),
         .q       (q_w[b])
      );
   end

   assign q      = q_w;
   assign is_max = (q_w == BCD_MAX);
   assign is_min = (q_w == BCD_MIN);

endmodule

// File: rtl/edge_trigger_JKFF.sv
// Rising-edge JK flip-flop with asynchronous active-low clear.
module edge_trigger_JKFF (
   input  logic clk,
   input  logic reset_n,
   input  logic j,
   input  logic k,
   output logic q
);

   logic q_q;
   logic q_d;

   always_comb begin
      q_d = q_q;
      case ({j, k})
         2'b10:   q_d = 1'b1;
         2'b01:   q_d = 1'b0;
         2'b11:   q_d = ~q_q;
         default: q_d = q_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q_q <= 1'b0;
      else          q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, enable and cascadable terminal count.
// Build option: BCD_CNT_SAT_EN selects saturation at all-9s / all-0s instead of wrapping.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        en,
   input  logic                        up_dn,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
   output logic [BCD_W*NUM_DIGITS-1:0] count,
   output logic                        tc
);

   logic [NUM_DIGITS-1:0] is_max;
   logic [NUM_DIGITS-1:0] is_min;
   logic [NUM_DIGITS-1:0] step;
   logic [NUM_DIGITS:0]   lower_term;
   logic                  advance;

   // lower_term[i]: every digit below i sits at its terminal value for this direction
   always_comb begin
      lower_term    = '0;
      lower_term[0] = 1'b1;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         lower_term[i+1] = lower_term[i] & (up_dn ? is_max[i] : is_min[i]);
      end
   end

`ifdef BCD_CNT_SAT_EN
   assign advance = en & ~load & ~lower_term[NUM_DIGITS];
`else
   assign advance = en & ~load;
`endif

   assign step = {NUM_DIGITS{advance}} & lower_term[NUM_DIGITS-1:0];
   assign tc   = reset_n & en & ~load & lower_term[NUM_DIGITS];

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk     (clk),
         .reset_n (reset_n),
         .step    (step[i]),
         .up_dn   (up_dn),
         .load    (load),
         .d       (load_val[BCD_W*i +: BCD_W]),
         .q       (count[BCD_W*i +: BCD_W]),
         .is_max  (is_max[i]),
         .is_min  (is_min[i])
      );
   end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Synchronous multi-digit BCD counter: NUM_DIGITS decade digits, counting up or down, with parallel load, count enable and a terminal-count output for cascading.
- Sits in the lab counter/timer datapath as the general-purpose successor to the fixed single-digit 0-9 up-counter.
- Every state bit is an edge_trigger_JKFF instance. J/K inputs are derived combinationally per digit.

Parameters:
- NUM_DIGITS, 2, number of BCD digits (1..8). Count width is 4*NUM_DIGITS.

Ports:
- clk, input, 1, rising-edge clock. Only clock in the block.
- reset_n, input, 1, asynchronous active-low reset. Clears all digits immediately.
- en, input, 1, count enable. Ignored while load=1.
- up_dn, input, 1, direction: 1 = up, 0 = down.
- load, input, 1, synchronous parallel load.
- load_val, input, 4*NUM_DIGITS, BCD load value. Digit i is bits [4i+3:4i].
- count, output, 4*NUM_DIGITS, current BCD value. Digit 0 is least significant.
- tc, output, 1, terminal count, combinational (see below).

Behaviour:
- Reset: reset_n=0 forces count=0 asynchronously, independent of clk. tc=0 while reset_n=0. The first active edge after release behaves normally.
- Priority at each rising clk edge: load > en > hold.
- Load: count <= load_val on the edge. Any digit in load_val with value 10..15 loads as 0; other digits are unaffected.
- Count up (en=1, up_dn=1, load=0):
  - Digit 0 increments.
  - Digit i increments only when digits 0..i-1 are all 9.
  - A digit at 9 that increments wraps to 0.
  - All-9s wraps to all-0s.
- Count down (en=1, up_dn=0, load=0):
  - Digit 0 decrements.
  - Digit i decrements only when digits 0..i-1 are all 0.
  - A digit at 0 that decrements wraps to 9.
  - All-0s wraps to all-9s.
- Hold (en=0, load=0): count unchanged.
- Latency: count reflects load/count one edge after sampling. tc has zero-cycle latency.
- tc = reset_n & en & ~load & (up_dn ? all digits == 9 : all digits == 0).
  - tc=1 means the next edge wraps the full counter.
  - Cascading: connect a lower stage's tc to the next stage's en.
- Direction change takes effect on the same edge it is sampled. No pipeline state.
- Digit values 10..15 are unreachable after reset. Only load could produce them, and load sanitises them.
- Reset asserted mid-count overrides any in-flight load or count immediately.

Optional Feature:
- Macro: BCD_CNT_SAT_EN.
- Defined (saturating mode):
  - Counting up at all-9s holds all-9s.
  - Counting down at all-0s holds all-0s.
  - tc is still asserted at the terminal value.
  - load is unaffected.
- Undefined: wrap-around as described in Behaviour.

Decomposition:
- Shared package bcd_pkg:
  - BCD_W=4
  - BCD_MAX=4'd9
  - BCD_MIN=4'd0
  - function bcd_sanitize (10..15 -> 0)
- Sub-module bcd_digit, one per digit, generated NUM_DIGITS times.
  - Inputs: clk, reset_n, step, up_dn, load, d[3:0].
  - Outputs: q[3:0], is_max, is_min.
  - Holds four edge_trigger_JKFF cells.
  - Load maps to J=d, K=~d.
  - Step maps to the BCD next-state J/K equations for the selected direction. Hold maps to J=K=0.
- Top level contents:
  - step chain: step_i = en & ~load & AND of is_max (up) or is_min (down) over lower digits.
  - tc computation.
  - Saturation gating under BCD_CNT_SAT_EN.

Test Plan:
- Reset/count: NUM_DIGITS=2, pulse reset_n low mid-cycle, then en=1, up_dn=1 for 12 edges -> count=00 immediately on reset; count=12 after 12 edges; digit-1 step occurs on the 09->10 edge.
- Up wrap and tc: load 98, en=1, up -> count 99 with tc=1, then 00 with tc=0 (wrap build). Same with BCD_CNT_SAT_EN -> holds 99, tc stays 1.
- Down wrap: load 01, en=1, up_dn=0 -> 00 with tc=1, then 99 (wrap build) or holds 00 (SAT build); 10 decrements to 09.
- Load priority and sanitise: load=1, en=1, load_val=0x3C -> count=30. load_val=0x47 with load=1, en=1 -> count=47, not 48.
- Hold and direction switch: count 55, en=0 for 5 edges -> stays 55. Then en=1 alternating up_dn each edge -> 56, 55, 56, 55.
- Cascade: two NUM_DIGITS=1 instances chained via tc->en, counting up from 0 -> combined value matches a NUM_DIGITS=2 instance cycle-for-cycle over 120 edges.
